// File: rtl/mux_pipe_rr.sv
// rtl/mux_pipe_rr.sv - N-way W-bit selector with one registered output stage
// Direct-select or round-robin grant; valid/ready on every input and on the output.
module mux_pipe_rr #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NPAD = 1 << SEL_W;

  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] candidate;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_cand;
  logic             rr_found;
  logic             sel_ok;
  logic [NPAD-1:0]  valid_pad;
  logic [WIDTH-1:0] cand_data;

  // Padding lets an out-of-range sel index safely; the pad bits are always 0.
  assign valid_pad = NPAD'(in_valid);
  assign load      = !out_valid || out_ready;
  assign sel_ok    = (int'(sel) < NUM_IN);

  // Search starts one past the last RR winner and wraps modulo NUM_IN.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    rr_cand  = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_s    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_IN;
      idx_s = SEL_W'(idx);
      if (!rr_found && valid_pad[idx_s]) begin
        rr_found = 1'b1;
        rr_cand  = idx_s;
      end
    end
  end

  always_comb begin
    candidate = '0;
    grant_vld = 1'b0;
    if (mode) begin
      candidate = rr_cand;
      grant_vld = rr_found;
    end else begin
      candidate = sel;
      grant_vld = sel_ok && valid_pad[sel];
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == candidate) begin
        cand_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (load && grant_vld) ? (NUM_IN'(1) << candidate) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(NUM_IN - 1);
    end else if (load && grant_vld) begin
      out_valid <= 1'b1;
      out_data  <= cand_data;
      out_src   <= candidate;
      if (mode) begin
        rr_ptr <= candidate;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_pipe_rr.sv
// tb/tb_mux_pipe_rr.sv - self-checking bench for mux_pipe_rr (NUM_IN=4 and NUM_IN=3)
// A queue-free behavioural model tracks both instances; directed vectors pin it.
module tb_mux_pipe_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode [2];
  logic [1:0]  sel  [2];
  logic [15:0] din  [2];
  logic [3:0]  vin  [2];
  logic        ordy [2];

  logic [3:0] rdy_a;
  logic [2:0] rdy_b;
  logic [3:0] dout_a, dout_b;
  logic [1:0] src_a, src_b;
  logic       ov_a, ov_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mux_pipe_rr #(.WIDTH(4), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .mode(mode[0]), .sel(sel[0]),
    .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy_a),
    .out_data(dout_a), .out_src(src_a), .out_valid(ov_a), .out_ready(ordy[0])
  );

  mux_pipe_rr #(.WIDTH(4), .NUM_IN(3)) dut_b (
    .clk(clk), .rst(rst), .mode(mode[1]), .sel(sel[1]),
    .in_data(din[1][11:0]), .in_valid(vin[1][2:0]), .in_ready(rdy_b),
    .out_data(dout_b), .out_src(src_b), .out_valid(ov_b), .out_ready(ordy[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [3:0] rdy_of(int d);
    return (d == 0) ? rdy_a : {1'b0, rdy_b};
  endfunction
  function automatic logic [3:0] dout_of(int d);
    return (d == 0) ? dout_a : dout_b;
  endfunction
  function automatic logic [1:0] src_of(int d);
    return (d == 0) ? src_a : src_b;
  endfunction
  function automatic logic ov_of(int d);
    return (d == 0) ? ov_a : ov_b;
  endfunction

  // Model state: what the output stage should hold after the last edge.
  bit         armed = 1'b0;
  logic       m_vld  [2];
  logic [3:0] m_data [2];
  int         m_src  [2];
  int         m_ptr  [2];

  always @(negedge clk) begin
    int         n, cand, idx;
    bit         gv, ld;
    logic [3:0] exp_rdy;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 4 : 3;
      if (armed) begin
        chk($sformatf("dut%0d out_valid", d), ov_of(d), m_vld[d]);
        chk($sformatf("dut%0d out_data", d), dout_of(d), m_data[d]);
        chk($sformatf("dut%0d out_src", d), src_of(d), m_src[d]);
      end
      ld   = !m_vld[d] || ordy[d];
      gv   = 1'b0;
      cand = 0;
      if (mode[d]) begin
        for (int k = 1; k <= n; k++) begin
          idx = (m_ptr[d] + k) % n;
          if (!gv && vin[d][idx]) begin
            gv   = 1'b1;
            cand = idx;
          end
        end
      end else if (int'(sel[d]) < n && vin[d][sel[d]]) begin
        gv   = 1'b1;
        cand = int'(sel[d]);
      end
      exp_rdy = (ld && gv) ? 4'(1 << cand) : 4'b0;
      if (armed) chk($sformatf("dut%0d in_ready", d), rdy_of(d), exp_rdy);
      if (rst) begin
        m_vld[d]  = 1'b0;
        m_data[d] = 4'h0;
        m_src[d]  = 0;
        m_ptr[d]  = n - 1;
      end else if (ld && gv) begin
        m_vld[d]  = 1'b1;
        m_data[d] = din[d][cand*4 +: 4];
        m_src[d]  = cand;
        if (mode[d]) m_ptr[d] = cand;
      end else if (ordy[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int seq_q [$];
  int exp2 [6] = '{0, 1, 2, 3, 0, 1};
  int exp3 [4] = '{3, 1, 3, 1};
  int exp6 [4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 1'b0; sel[d] = 2'd0; din[d] = 16'h0; vin[d] = 4'h0; ordy[d] = 1'b1;
    end
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", ov_a, 0);
    chk("reset out_data", dout_a, 0);
    chk("reset out_src", src_a, 0);

    // T1 direct select of channel 2
    cyc();
    sel[0] = 2'd2; din[0] = 16'h0A00; vin[0] = 4'b0100;
    @(negedge clk);
    chk("t1 in_ready", rdy_a, 4'b0100);
    cyc();
    vin[0] = 4'h0;
    @(negedge clk);
    chk("t1 out_valid", ov_a, 1);
    chk("t1 out_data", dout_a, 4'hA);
    chk("t1 out_src", src_a, 2);

    // T2 round-robin, all valid; direct transfer must not have moved the pointer
    cyc();
    mode[0] = 1'b1; vin[0] = 4'hF; din[0] = 16'h4321;
    seq_q.delete();
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t2 out_valid", ov_a, 1);
      seq_q.push_back(int'(src_a));
    end
    for (int k = 0; k < 6; k++) chk($sformatf("t2 src[%0d]", k), seq_q[k], exp2[k]);

    // T3 only channels 1 and 3 valid
    vin[0] = 4'b1010; din[0] = 16'h7050;
    seq_q.delete();
    for (int k = 0; k < 4; k++) begin
      cyc();
      seq_q.push_back(int'(src_a));
    end
    for (int k = 0; k < 4; k++) chk($sformatf("t3 src[%0d]", k), seq_q[k], exp3[k]);

    // T4 backpressure, then drain and reload in one cycle
    ordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4 stall in_ready", rdy_a, 4'b0000);
      chk("t4 stall out_data", dout_a, 4'h5);
      chk("t4 stall out_src", src_a, 1);
      cyc();
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("t4 release in_ready", rdy_a, 4'b1000);
    cyc();
    chk("t4 reload out_src", src_a, 3);
    chk("t4 reload out_data", dout_a, 4'h7);
    chk("t4 reload out_valid", ov_a, 1);

    // T5 reset with a stalled word and pending inputs
    vin[0] = 4'b0010;
    cyc();
    vin[0] = 4'hF; ordy[0] = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; ordy[0] = 1'b1;
    chk("t5 out_valid", ov_a, 0);
    chk("t5 out_data", dout_a, 0);
    @(negedge clk);
    chk("t5 in_ready", rdy_a, 4'b0001);
    cyc();
    chk("t5 out_src", src_a, 0);

    // T6 three-channel instance: out-of-range sel, then RR wrap modulo 3
    sel[1] = 2'd3; din[1] = 16'h0321; vin[1] = 4'b0111;
    @(negedge clk);
    chk("t6 in_ready", rdy_b, 3'b000);
    cyc();
    chk("t6 out_valid", ov_b, 0);
    mode[1] = 1'b1;
    seq_q.delete();
    for (int k = 0; k < 4; k++) begin
      cyc();
      seq_q.push_back(int'(src_b));
    end
    for (int k = 0; k < 4; k++) chk($sformatf("t6 src[%0d]", k), seq_q[k], exp6[k]);

    vin[0] = 4'h0; vin[1] = 4'h0;
    cyc(); cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
